scoreboard_core: RTL

- Parametrised successor to the fixed single-scoreboard user project. Generalised to N teams and D BCD digits per team.
- Function: debounces raw pad buttons, keeps per-team saturating BCD scores, and drives a time-multiplexed 7-segment display.
- Instantiated inside the user project, with pads routed from io_in/io_out/io_oeb.

---
 rtl/scoreboard_core_if.sv | 26 ++
 rtl/scoreboard_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_core_if.sv
// Pad-side bundle for scoreboard_core: raw buttons in, packed BCD scores and
// multiplexed 7-segment display out. The core uses the slave modport.
interface scoreboard_core_if #(
  parameter int NUM_TEAMS    = 2,
  parameter int SCORE_DIGITS = 2
);
  localparam int ND = NUM_TEAMS * SCORE_DIGITS;

  logic [NUM_TEAMS-1:0] btn_inc_i;
  logic [NUM_TEAMS-1:0] btn_dec_i;
  logic                 btn_clr_i;
  logic [ND*4-1:0]      score_o;
  logic [6:0]           seg_o;
  logic [ND-1:0]        dig_en_o;
  logic [6+ND:0]        io_oeb_o;

  modport master (
    output btn_inc_i, btn_dec_i, btn_clr_i,
    input  score_o, seg_o, dig_en_o, io_oeb_o
  );

  modport slave (
    input  btn_inc_i, btn_dec_i, btn_clr_i,
    output score_o, seg_o, dig_en_o, io_oeb_o
  );
endinterface

// File: rtl/scoreboard_core.sv
// Debounced N-team BCD scoreboard with a scanned 7-segment display; a press lands on score_o DEBOUNCE_CYCLES+3 cycles after first sample.
// Scores saturate by default; defining SCOREBOARD_ROLLOVER_EN makes inc/dec wrap at the limits instead.
module scoreboard_core #(
  parameter int NUM_TEAMS       = 2,
  parameter int SCORE_DIGITS    = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SCAN_DIV        = 10000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  scoreboard_core_if.slave bus
);
  localparam int NB = 2 * NUM_TEAMS + 1;
  localparam int ND = NUM_TEAMS * SCORE_DIGITS;
  localparam int DW = SCORE_DIGITS * 4;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [DW-1:0] MAX_SCORE = {SCORE_DIGITS{4'h9}};

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Button order: inc[NUM_TEAMS-1:0], dec[NUM_TEAMS-1:0], clr on top.
  logic [NB-1:0] raw;
  assign raw = {bus.btn_clr_i, bus.btn_dec_i, bus.btn_inc_i};

  logic [NB-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]         db_q, db_d, db_prev_q, db_prev_d, ev_q, ev_d;
  logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
  logic [ND*4-1:0]       score_q, score_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [ND-1:0]         dig_en_q, dig_en_d;
  logic [6:0]            seg_q, seg_d;
  logic [DW-1:0]         cur;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    for (int b = 0; b < NB; b++) begin
      if (sync2_q[b] != db_q[b]) begin
        if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[b]  = ~db_q[b];
          cnt_d[b] = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end else begin
        cnt_d[b] = '0;
      end
    end
    db_prev_d = db_q;
    ev_d      = db_q & ~db_prev_q;
  end

  // Clear wins over everything; inc and dec together on one team cancel.
  always_comb begin
    score_d = score_q;
    cur     = '0;
    if (ev_q[NB-1]) begin
      score_d = '0;
    end else begin
      for (int t = 0; t < NUM_TEAMS; t++) begin
        cur = score_q[t*DW +: DW];
        if (ev_q[t] && !ev_q[NUM_TEAMS+t]) begin
`ifdef SCOREBOARD_ROLLOVER_EN
          score_d[t*DW +: DW] = bcd_inc(cur);
`else
          if (cur != MAX_SCORE) score_d[t*DW +: DW] = bcd_inc(cur);
`endif
        end else if (ev_q[NUM_TEAMS+t] && !ev_q[t]) begin
`ifdef SCOREBOARD_ROLLOVER_EN
          score_d[t*DW +: DW] = bcd_dec(cur);
`else
          if (cur != '0) score_d[t*DW +: DW] = bcd_dec(cur);
`endif
        end
      end
    end
  end

  // Segments track the live nibble, so a score change shows on the next refresh.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(ND - 1)) ? '0 : idx_q + 1'b1;
    end
    dig_en_d        = '0;
    dig_en_d[idx_q] = 1'b1;
    seg_d           = seg7(score_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      ev_q      <= '0;
      cnt_q     <= '0;
      score_q   <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      dig_en_q  <= ND'(1);
      seg_q     <= 7'b0111111;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      ev_q      <= ev_d;
      cnt_q     <= cnt_d;
      score_q   <= score_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dig_en_q  <= dig_en_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.score_o  = score_q;
  assign bus.seg_o    = seg_q;
  assign bus.dig_en_o = dig_en_q;
  assign bus.io_oeb_o = '0;
endmodule
